// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner of one gated bus shared by N requesters.
// Each winner gets a burst of max(len,1) cycles. Consecutive bursts are
// separated by one all-zero TURN cycle, so two sources never drive the
// wired bus in the same cycle.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - synchronous active-high reset
//   req    - [N] per-source bus request
//   len    - [LEN_W] burst length, sampled only when arbitrating
//   enable - [N] registered one-hot-or-zero bus gate enables
//   owner  - [$clog2(N)] index of the current or most recent grantee
//   busy   - high whenever any enable bit is high
//   done   - one-cycle pulse (in TURN) marking burst completion
module bus_arbiter #(
   parameter int N     = 4,
   parameter int LEN_W = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         req,
   input  logic [LEN_W-1:0]     len,
   output logic [N-1:0]         enable,
   output logic [$clog2(N)-1:0] owner,
   output logic                 busy,
   output logic                 done
);
   localparam int IW = $clog2(N);

   typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

   state_t           r_state, w_state_nxt;
   logic [N-1:0]     r_enable, w_enable_nxt;
   logic [IW-1:0]    r_owner, w_owner_nxt;
   logic [IW-1:0]    r_ptr, w_ptr_nxt;
   logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_done, w_done_nxt;

   logic             w_any;
   logic [IW-1:0]    w_win;
   logic [LEN_W-1:0] w_len_eff;
   logic             w_last;
   logic [IW-1:0]    w_owner_inc;

   // First set request at or above p, wrapping from N-1 back to 0.
   function automatic logic [IW-1:0] f_pick(input logic [N-1:0] rq,
                                            input logic [IW-1:0] p);
      logic [IW-1:0] win;
      logic          found;
      int            idx;
      win   = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(p) + k) % N;
         if (!found && rq[idx]) begin
            found = 1'b1;
            win   = IW'(idx);
         end
      end
      return win;
   endfunction

   assign w_any       = |req;
   assign w_win       = f_pick(req, r_ptr);
   assign w_len_eff   = (len == '0) ? LEN_W'(1) : len;  // len=0 acts as 1
   assign w_last      = (r_cnt == LEN_W'(1));
   assign w_owner_inc = (r_owner == IW'(N - 1)) ? '0 : r_owner + IW'(1);

   always_comb begin
      w_state_nxt  = r_state;
      w_enable_nxt = '0;
      w_owner_nxt  = r_owner;
      w_ptr_nxt    = r_ptr;
      w_cnt_nxt    = r_cnt;
      w_done_nxt   = 1'b0;
      case (r_state)
         IDLE, TURN: begin
            if (w_any) begin
               w_state_nxt  = GRANT;
               w_enable_nxt = {{(N-1){1'b0}}, 1'b1} << w_win;
               w_owner_nxt  = w_win;
               w_cnt_nxt    = w_len_eff;
            end else begin
               w_state_nxt  = IDLE;
            end
         end
         GRANT: begin
            // A dropped request on the final cycle still counts as completion.
            if (!req[r_owner] || w_last) begin
               w_state_nxt = TURN;
               w_done_nxt  = w_last;
               w_ptr_nxt   = w_owner_inc;
            end else begin
               w_enable_nxt = r_enable;
               w_cnt_nxt    = r_cnt - LEN_W'(1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_enable <= '0;
         r_owner  <= '0;
         r_ptr    <= '0;
         r_cnt    <= '0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_enable <= w_enable_nxt;
         r_owner  <= w_owner_nxt;
         r_ptr    <= w_ptr_nxt;
         r_cnt    <= w_cnt_nxt;
         r_done   <= w_done_nxt;
      end
   end

   assign enable = r_enable;
   assign owner  = r_owner;
   assign busy   = |r_enable;
   assign done   = r_done;
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter N, default 4, SHALL set the number of requesters sharing one gated bus (N >= 2).
REQ-002 Parameter LEN_W, default 4, SHALL set the width of the burst-length input.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-005 Port req, input, N bits, SHALL carry one bus request per requester; bit i requests ownership for source i.
REQ-006 Port len, input, LEN_W bits, SHALL give the burst length in cycles, sampled only in the arbitration cycle.
REQ-007 Port enable, output, N bits, SHALL be a registered one-hot-or-zero vector, one bit per source, driving the per-source bus gate enables.
REQ-008 Port owner, output, $clog2(N) bits, SHALL be the index of the current or most recent grantee.
REQ-009 Port busy, output, 1 bit, SHALL be high in every cycle any enable bit is high.
REQ-010 Port done, output, 1 bit, SHALL be a one-cycle pulse marking burst completion.

Function
REQ-011 States SHALL be IDLE, GRANT and TURN.
REQ-012 enable SHALL never have more than one bit set, in any cycle and state.
REQ-013 enable SHALL be all-zero in IDLE and TURN; only GRANT drives one bit (turnaround guarantees no two sources overlap on the wired bus).
REQ-014 Arbitration SHALL occur in IDLE and TURN: with any req bit set, winner = first set bit searching upward from pointer ptr, wrapping N-1 -> 0.
REQ-015 On arbitration with a winner, next state SHALL be GRANT with enable[winner]=1, owner=winner, counter loaded with len.
REQ-016 With no req bit set, IDLE SHALL remain IDLE and TURN SHALL go to IDLE.
REQ-017 Latency SHALL be exactly one cycle: req sampled high at edge k in IDLE/TURN -> enable bit high after edge k.
REQ-018 GRANT SHALL last max(len,1) cycles; len=0 SHALL behave as len=1.
REQ-019 On the last GRANT cycle, next state SHALL be TURN, and done SHALL be high in that TURN cycle only.
REQ-020 If req[owner] is low in any GRANT cycle, the burst SHALL abort: next state TURN, done stays low.
REQ-021 An abort and the natural last cycle coinciding SHALL count as completion (done pulses).
REQ-022 On leaving GRANT, ptr SHALL become owner+1 modulo N (round-robin fairness); ptr unchanged otherwise.
REQ-023 Changes to len or other req bits during GRANT SHALL have no effect on the current burst.
REQ-024 owner SHALL hold its value through TURN and IDLE until the next grant.
REQ-025 Back-to-back bursts SHALL be separated by exactly one all-zero TURN cycle.

Reset
REQ-026 While reset is high at a clock edge: state=IDLE, enable=0, busy=0, done=0, owner=0, ptr=0, counter=0.
REQ-027 reset SHALL override all other inputs, including mid-GRANT; enable drops to zero after that same edge with no done pulse.
REQ-028 After reset deasserts, the first arbitration SHALL favour source 0.

Verification
REQ-029 N=4: reset, then req=4'b0100, len=3 -> enable=4'b0100 for 3 cycles starting one cycle after req, then TURN with done=1, enable=0, owner=2.
REQ-030 req=4'b1111 held, len=1 -> grants rotate 0,1,2,3,0 with one zero-enable TURN cycle between each; done pulses every second cycle.
REQ-031 len=0, req=4'b0001 -> single-cycle enable=4'b0001, then done=1.
REQ-032 len=5, req[1] granted, req[1] dropped in second GRANT cycle -> enable=0 next cycle, done stays 0, ptr=2.
REQ-033 reset asserted during third cycle of a len=8 burst -> enable=0, busy=0, owner=0 after that edge; no done pulse.
REQ-034 All scenarios: checker asserts $onehot0(enable) and busy==|enable every cycle.
